// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants, state encoding and status-word helper for the buffered UART transmitter.
package uart_tx_fifo_pkg;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_1004;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uartState_e;

  // Word returned to loads from UART_STATUS_ADDR.
  function automatic logic [31:0] uartStatusWord(input logic ovfIn, input logic busyIn,
                                                 input logic fullIn, input logic emptyIn,
                                                 input logic [7:0] lvlIn);
    return {20'd0, ovfIn, busyIn, fullIn, emptyIn, lvlIn};
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with registered level/full/empty; pushes while full are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstd,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             pushOk, popOk;

  assign pushOk  = push && !full_q;
  assign popOk   = pop && !empty_q;
  assign level_d = level_q + LW'(pushOk) - LW'(popOk);

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign pop_data = mem_q[rdPtr_q];
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a frame FSM that serialises start, data, parity and stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = UART_PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rstd,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          ovf_clr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          uart_tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_badClks
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_badData
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_badParity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  logic                 fifoPop, fifoFull, fifoEmpty;
  logic [DATA_BITS-1:0] fifoData;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .rstd      (rstd),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifoPop),
    .pop_data  (fifoData),
    .level     (level),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign full  = fifoFull;
  assign empty = fifoEmpty;

  // Set wins over clear so a drop in the same cycle as ovf_clr is never lost.
  logic ovf_q;
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) ovf_q <= 1'b0;
    else       ovf_q <= (ovf_q && !ovf_clr) || (wr_en && fifoFull);
  end
  assign overflow = ovf_q;

  uartState_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 stopIdx_q, stopIdx_d;
  logic                 tx_q, tx_d;
  logic                 bitDone;

  assign bitDone = (timer_q == '0);

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q   <= UART_ST_IDLE;
      timer_q   <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      stopIdx_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      stopIdx_q <= stopIdx_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    stopIdx_d = stopIdx_q;
    fifoPop   = 1'b0;
    if (state_q != UART_ST_IDLE && !bitDone) begin
      timer_d = timer_q - TW'(1);
    end
    unique case (state_q)
      UART_ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          shift_d  = fifoData;
          parity_d = ^fifoData;
          timer_d  = BIT_LOAD;
          state_d  = UART_ST_START;
        end
      end
      UART_ST_START: begin
        if (bitDone) begin
          bitIdx_d = '0;
          timer_d  = BIT_LOAD;
          state_d  = UART_ST_DATA;
        end
      end
      UART_ST_DATA: begin
        if (bitDone) begin
          timer_d = BIT_LOAD;
          if (bitIdx_q == IW'(DATA_BITS - 1)) begin
            stopIdx_d = 1'b0;
            state_d   = (PARITY != UART_PARITY_NONE) ? UART_ST_PARITY : UART_ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + IW'(1);
            shift_d  = shift_q >> 1;
          end
        end
      end
      UART_ST_PARITY: begin
        if (bitDone) begin
          stopIdx_d = 1'b0;
          timer_d   = BIT_LOAD;
          state_d   = UART_ST_STOP;
        end
      end
      UART_ST_STOP: begin
        if (bitDone) begin
          timer_d = BIT_LOAD;
          if (stopIdx_q == 1'(STOP_BITS - 1)) begin
            if (!fifoEmpty) begin
              fifoPop  = 1'b1;
              shift_d  = fifoData;
              parity_d = ^fifoData;
              state_d  = UART_ST_START;
            end else begin
              state_d  = UART_ST_IDLE;
            end
          end else begin
            stopIdx_d = 1'b1;
          end
        end
      end
      default: state_d = UART_ST_IDLE;
    endcase
  end

  // Line level is decided from the upcoming state and registered so the pin never glitches.
  always_comb begin
    tx_d = 1'b1;
    busy = (state_q != UART_ST_IDLE);
    unique case (state_d)
      UART_ST_START:  tx_d = 1'b0;
      UART_ST_DATA:   tx_d = shift_d[0];
      UART_ST_PARITY: tx_d = (PARITY == UART_PARITY_ODD) ? ~parity_d : parity_d;
      default:        tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: cycle-level line model for the main instance plus parity/stop table on two more.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rstd;
  always #5 clk = ~clk;

  logic          wrEn, ovfClr;
  logic [7:0]    wrData;
  logic          full, empty, busy, overflow, uartTx;
  logic [LW-1:0] level;

  logic       evWrEn, odWrEn, parOvfClr;
  logic [7:0] evWrData, odWrData;
  logic       evFull, evEmpty, evBusy, evOvf, evTx;
  logic       odFull, odEmpty, odBusy, odOvf, odTx;
  logic [4:0] evLevel, odLevel;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rstd(rstd), .wr_en(wrEn), .wr_data(wrData), .ovf_clr(ovfClr),
    .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow), .uart_tx(uartTx));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dutEven (
    .clk(clk), .rstd(rstd), .wr_en(evWrEn), .wr_data(evWrData), .ovf_clr(parOvfClr),
    .full(evFull), .empty(evEmpty), .level(evLevel), .busy(evBusy), .overflow(evOvf), .uart_tx(evTx));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutOdd (
    .clk(clk), .rstd(rstd), .wr_en(odWrEn), .wr_data(odWrData), .ovf_clr(parOvfClr),
    .full(odFull), .empty(odEmpty), .level(odLevel), .busy(odBusy), .overflow(odOvf), .uart_tx(odTx));

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a frame offset; the line is read from the frame bit pattern.
  logic [7:0] mQ[$];
  bit         mActive;
  int         mOff;
  logic [9:0] mFrame;
  bit         mOvf;

  always @(posedge clk or negedge rstd) begin
    bit fullPrev, emptyPrev, doPop;
    logic [7:0] head;
    if (!rstd) begin
      mQ.delete();
      mActive = 1'b0;
      mOff    = 0;
      mOvf    = 1'b0;
    end else begin
      fullPrev  = (mQ.size() == DEPTH);
      emptyPrev = (mQ.size() == 0);
      doPop     = 1'b0;
      if (mActive) begin
        if (mOff == FRAME - 1) begin
          if (!emptyPrev) doPop = 1'b1;
          else            mActive = 1'b0;
        end else begin
          mOff++;
        end
      end else if (!emptyPrev) begin
        doPop = 1'b1;
      end
      if (doPop) begin
        head    = mQ.pop_front();
        mFrame  = {1'b1, head, 1'b0};
        mActive = 1'b1;
        mOff    = 0;
      end
      if (wrEn && !fullPrev) mQ.push_back(wrData);
      mOvf = (mOvf && !ovfClr) || (wrEn && fullPrev);
    end
  end

  always @(negedge clk) begin
    logic [LW+4:0] expV, actV;
    logic          expTx;
    if (checkEn) begin
      expTx = mActive ? mFrame[mOff / CPB] : 1'b1;
      expV  = {expTx, mActive, (mQ.size() == DEPTH), (mQ.size() == 0), mOvf, LW'(mQ.size())};
      actV  = {uartTx, busy, full, empty, overflow, level};
      checks++;
      if (actV !== expV) begin
        errors++;
        $display("[TB] FAIL model tx/busy/full/empty/ovf/level actual=%b required=%b at %0t",
                 actV, expV, $time);
      end
    end
  end

  // Serial decoder on the main line; realigns on the next falling edge after any disturbance.
  logic [7:0] rxQ[$];
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (uartTx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uartTx;
      end
      repeat (CPB) @(negedge clk);
      rxQ.push_back(b);
      @(negedge clk);
    end
  end

  task automatic applyStimulus(input logic [7:0] d);
    wrEn = 1'b1; wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int g = 0;
    while ((busy || !empty) && g < 2000) begin @(negedge clk); g++; end
    checkOutput(name, (g >= 2000), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic selTx(input bit odd);
    return odd ? odTx : evTx;
  endfunction

  function automatic logic selBusy(input bit odd);
    return odd ? odBusy : evBusy;
  endfunction

  typedef struct {
    bit         odd;
    logic [7:0] data;
    bit         expPar;
    int         expCycles;
  } parVec_t;

  parVec_t parTab[6];

  initial begin
    int cnt, maxLvl, dens;

    parTab[0] = '{1'b0, 8'h07, 1'b1, 48};
    parTab[1] = '{1'b1, 8'h07, 1'b0, 48};
    parTab[2] = '{1'b0, 8'h03, 1'b0, 48};
    parTab[3] = '{1'b1, 8'h03, 1'b1, 48};
    parTab[4] = '{1'b0, 8'h80, 1'b1, 48};
    parTab[5] = '{1'b1, 8'hFF, 1'b1, 48};

    rstd = 1'b0; wrEn = 1'b0; wrData = '0; ovfClr = 1'b0;
    evWrEn = 1'b0; odWrEn = 1'b0; evWrData = '0; odWrData = '0; parOvfClr = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset tx", uartTx, 1);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset level", level, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset overflow", overflow, 0);
    rstd = 1'b1;
    checkEn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: start two edges after the push, busy for one frame length.
    wrEn = 1'b1; wrData = 8'h55;
    @(negedge clk);
    wrEn = 1'b0;
    checkOutput("single tx before pop", uartTx, 1);
    @(negedge clk);
    checkOutput("single tx falls", uartTx, 0);
    cnt = 0;
    while (busy && cnt < 200) begin @(negedge clk); cnt++; end
    checkOutput("single busy duration", cnt, FRAME);
    waitIdle("single idle");

    // Three back-to-back frames.
    rxQ.delete();
    maxLvl = 0;
    for (int i = 0; i < 3; i++) begin
      wrEn = 1'b1; wrData = 8'h41 + 8'(i);
      @(negedge clk);
      if (int'(level) > maxLvl) maxLvl = int'(level);
    end
    wrEn = 1'b0;
    cnt = 1;
    while (busy && cnt < 400) begin
      @(negedge clk); cnt++;
      if (int'(level) > maxLvl) maxLvl = int'(level);
    end
    checkOutput("burst3 duration", cnt, 3 * FRAME);
    checkOutput("burst3 level peak", maxLvl, 2);
    waitIdle("burst3 idle");
    checkOutput("burst3 rx count", rxQ.size(), 3);
    for (int i = 0; i < 3 && i < rxQ.size(); i++) checkOutput("burst3 rx byte", rxQ[i], 8'h41 + 8'(i));

    // Overflow: six pushes into a depth-4 FIFO that drains one byte meanwhile.
    rxQ.delete();
    for (int i = 0; i < 6; i++) begin
      wrEn = 1'b1; wrData = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wrEn = 1'b0;
    checkOutput("ovf set", overflow, 1);
    waitIdle("ovf idle");
    checkOutput("ovf still set", overflow, 1);
    checkOutput("ovf rx count", rxQ.size(), 5);
    for (int i = 0; i < 5 && i < rxQ.size(); i++) checkOutput("ovf rx byte", rxQ[i], 8'h10 + 8'(i));
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("ovf cleared", overflow, 0);

    // Parity and two stop bits, table driven.
    for (int r = 0; r < 6; r++) begin
      logic [11:0] bits;
      int off, guard;
      if (parTab[r].odd) begin odWrEn = 1'b1; odWrData = parTab[r].data; end
      else               begin evWrEn = 1'b1; evWrData = parTab[r].data; end
      @(negedge clk);
      odWrEn = 1'b0; evWrEn = 1'b0;
      guard = 0;
      while (selTx(parTab[r].odd) !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
      checkOutput("par start latency", guard, 1);
      off = 0;
      for (int b = 0; b < 12; b++) begin
        while (off < CPB * b + CPB / 2) begin @(negedge clk); off++; end
        bits[b] = selTx(parTab[r].odd);
      end
      while (selBusy(parTab[r].odd) && off < 200) begin @(negedge clk); off++; end
      checkOutput("par start bit", bits[0], 0);
      checkOutput("par data bits", bits[8:1], parTab[r].data);
      checkOutput("par parity bit", bits[9], parTab[r].expPar);
      checkOutput("par stop bits", bits[11:10], 2'b11);
      checkOutput("par frame cycles", off, parTab[r].expCycles);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of data bit 3 with two bytes still queued.
    for (int i = 0; i < 3; i++) begin
      wrEn = 1'b1; wrData = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    wrEn = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("midreset level before", level, 2);
    checkEn = 1'b0;
    #2 rstd = 1'b0;
    #1;
    checkOutput("midreset tx", uartTx, 1);
    checkOutput("midreset level", level, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset empty", empty, 1);
    repeat (2) @(negedge clk);
    rstd = 1'b1;
    checkEn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uartTx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    checkOutput("midreset line stays idle", cnt, 0);

    // Randomised traffic with alternating density and one asynchronous reset.
    dens = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = (dens == 2) ? 40 : 2;
      wrEn   = ($urandom_range(0, dens) == 0);
      wrData = 8'($urandom);
      ovfClr = ($urandom_range(0, 31) == 0);
      if (c == 1500) begin
        #2 rstd = 1'b0;
        @(negedge clk);
        #2 rstd = 1'b1;
      end
      @(negedge clk);
    end
    wrEn = 1'b0; ovfClr = 1'b0;
    waitIdle("random drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered successor to the single-byte memory-mapped UART transmitter used by the cpu top. Store-path writes go into an internal FIFO, so software can issue bursts without polling per byte. A frame FSM drains the FIFO onto the serial line with configurable data width, parity and stop bits. Status outputs (full/empty/level/busy/overflow) feed a memory-mapped status word that loads can read.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rstd  in  1  asynchronous reset, active-low
wr_en  in  1  push strobe; store to UART_ADDR with is_store asserted
wr_data  in  DATA_BITS  byte to transmit (rs2 low bits)
ovf_clr  in  1  clears sticky overflow
full  out  1  FIFO holds FIFO_DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not in IDLE
overflow  out  1  sticky: a push was dropped
uart_tx  out  1  serial line; idle high

Behaviour:
- Reset (rstd low, async): uart_tx=1, state IDLE, FIFO pointers 0, level=0, empty=1, full=0, busy=0, overflow=0. Takes effect immediately, including mid-frame. Any partial frame is abandoned and the line returns high.
- Push: on a clk edge with wr_en=1 and full=0, store wr_data and increment level.
- Push with full=1 (registered value): drop the data and set overflow=1. This also applies when a pop happens on the same edge. No write-through.
- ovf_clr=1 clears overflow on the next edge. If an overflow event and ovf_clr occur on the same edge, overflow ends at 1 (set wins).
- Same-edge push and pop: level unchanged.
- Pointers wrap modulo FIFO_DEPTH. full and empty are derived from level and are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if empty=0, pop the head into the shift register, go to START, and drive uart_tx=0 from that edge.
- Latency: wr_en sampled at edge N into an empty FIFO gives empty=0 after N. Pop occurs at N+1, so uart_tx falls after edge N+1.
- Bit timer: loads CLKS_PER_BIT-1 on entry to each bit and counts down. The bit ends when the timer reaches 0, so every bit lasts exactly CLKS_PER_BIT cycles.
- START: one bit of 0, then DATA.
- DATA: DATA_BITS bits, LSB first. A bit index counts 0..DATA_BITS-1. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: STOP_BITS bits of 1. At the end of the last stop bit:
  - if empty=0, pop and enter START directly (no idle gap);
  - otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy=1 in every state except IDLE.
- uart_tx is driven from a register only (glitch-free).
- Out-of-range parameters are caught by a generate-time $error.

Decomposition:
- define.vh additions:
  - UART_PARITY_NONE/EVEN/ODD
  - UART state encodings (3-bit)
  - UART_STATUS_ADDR, whose status word packs {overflow, busy, full, empty, level}
- Sub-module sync_fifo:
  - parameters WIDTH, DEPTH
  - ports clk, rstd, push, push_data, pop, pop_data, level, full, empty
  - reusable for a later receive path
- The FSM, bit timer and shift register stay in uart_tx_fifo.

Test Plan:
1. Assert rstd=0 for 3 cycles -> uart_tx=1, empty=1, level=0, busy=0, overflow=0.
2. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; write 0x55 once -> uart_tx falls 2 edges after wr_en. Serial bits are 0,1,0,1,0,1,0,1,0,1, each 4 cycles. busy drops 40 cycles after the start edge.
3. Write 0x41, 0x42, 0x43 on consecutive cycles -> three frames back-to-back totalling 120 cycles, with no high gap between a stop bit and the next start bit. Level peaks at 2.
4. FIFO_DEPTH=4; write bytes 0x10..0x15 on 6 consecutive cycles -> 0x10..0x14 are sent in order, 0x15 is dropped, overflow=1. Overflow stays set until ovf_clr is pulsed, then reads 0.
5. PARITY=1, STOP_BITS=2; send 0x07 -> parity bit 1, frame of 12 bits = 48 cycles. With PARITY=2 the parity bit is 0.
6. Assert rstd=0 during DATA bit 3 with 2 bytes queued -> uart_tx=1 immediately, level=0. After release, the line stays idle and no frame is emitted.
